// File: rtl/sram_scan_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_scan_burst_ctrl
// Purpose  : Framed single-bit scan engine that bursts words into / out of a
//            synchronous SRAM port (start bit, header, contiguous payload).
// Revision : 1.0 - initial release
// ============================================================================
module sram_scan_burst_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 16
) (
  input  logic              clk_1,
  input  logic              rst_n_sync,
  input  logic              scan_in,
  output logic              scan_out,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int c_HDR_W = 1 + CNT_W + ADDR_W;
  localparam int c_MAX_W = (c_HDR_W > DATA_W) ? c_HDR_W : DATA_W;
  localparam int c_BIT_W = $clog2(c_MAX_W);

  localparam logic [c_BIT_W-1:0] c_HDR_LAST = c_BIT_W'(c_HDR_W - 1);
  localparam logic [c_BIT_W-1:0] c_DAT_LAST = c_BIT_W'(DATA_W - 1);
  localparam logic [c_BIT_W-1:0] c_BIT_ONE  = c_BIT_W'(1);

  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_HDR     = 3'd1;
  localparam logic [2:0] c_ST_WR_DATA = 3'd2;
  localparam logic [2:0] c_ST_RD_DATA = 3'd3;
  localparam logic [2:0] c_ST_DONE    = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [c_BIT_W-1:0] r_bit_cnt,  w_bit_cnt_nxt;
  logic [c_HDR_W-2:0] r_hdr_sh,   w_hdr_sh_nxt;
  logic [DATA_W-1:0]  r_dat_sh,   w_dat_sh_nxt;
  logic [CNT_W-1:0]   r_word,     w_word_nxt;
  logic [CNT_W-1:0]   r_count,    w_count_nxt;
  logic [ADDR_W-1:0]  r_base,     w_base_nxt;
  logic               r_last,     w_last_nxt;

  logic               w_scan_out_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic               w_mem_en_nxt;
  logic               w_mem_we_nxt;
  logic [ADDR_W-1:0]  w_mem_addr_nxt;
  logic [DATA_W-1:0]  w_mem_din_nxt;

  logic [c_HDR_W-1:0] w_hdr;
  logic [DATA_W-1:0]  w_wr_word;
  logic [ADDR_W-1:0]  w_word_addr;
  logic               w_hdr_last;
  logic               w_dat_last;

  assign w_hdr       = {scan_in, r_hdr_sh};
  assign w_wr_word   = {scan_in, r_dat_sh[DATA_W-1:1]};
  assign w_word_addr = r_base + ADDR_W'(r_word);
  assign w_hdr_last  = (r_bit_cnt == c_HDR_LAST);
  assign w_dat_last  = (r_bit_cnt == c_DAT_LAST);

  always_ff @(posedge clk_1 or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:    if (scan_in) w_state_nxt = c_ST_HDR;
      c_ST_HDR:     if (w_hdr_last) w_state_nxt = w_hdr[0] ? c_ST_WR_DATA : c_ST_RD_DATA;
      c_ST_WR_DATA: if (w_dat_last && (r_word == r_count)) w_state_nxt = c_ST_DONE;
      c_ST_RD_DATA: if (w_dat_last && r_last) w_state_nxt = c_ST_DONE;
      c_ST_DONE:    w_state_nxt = c_ST_IDLE;
      default:      w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_scan_out_nxt = 1'b0;
    w_busy_nxt     = busy;
    w_done_nxt     = 1'b0;
    w_mem_en_nxt   = 1'b0;
    w_mem_we_nxt   = mem_we;
    w_mem_addr_nxt = mem_addr;
    w_mem_din_nxt  = mem_din;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_hdr_sh_nxt   = r_hdr_sh;
    w_dat_sh_nxt   = r_dat_sh;
    w_word_nxt     = r_word;
    w_count_nxt    = r_count;
    w_base_nxt     = r_base;
    w_last_nxt     = r_last;
    case (r_state)
      c_ST_IDLE: begin
        if (scan_in) begin
          w_busy_nxt    = 1'b1;
          w_bit_cnt_nxt = '0;
        end
      end
      c_ST_HDR: begin
        w_hdr_sh_nxt  = w_hdr[c_HDR_W-1:1];
        w_bit_cnt_nxt = r_bit_cnt + c_BIT_ONE;
        if (w_hdr_last) begin
          w_count_nxt  = w_hdr[CNT_W:1];
          w_base_nxt   = w_hdr[c_HDR_W-1:CNT_W+1];
          w_word_nxt   = '0;
          w_last_nxt   = 1'b0;
          w_dat_sh_nxt = '0;
          // Reads start one slot "before" bit 0 so the word-0 fetch reuses the
          // normal end-of-word prefetch path; the cleared shifter keeps scan_out low.
          w_bit_cnt_nxt = w_hdr[0] ? '0 : c_DAT_LAST;
        end
      end
      c_ST_WR_DATA: begin
        w_dat_sh_nxt  = w_wr_word;
        w_bit_cnt_nxt = w_dat_last ? '0 : (r_bit_cnt + c_BIT_ONE);
        if (w_dat_last) begin
          w_mem_en_nxt   = 1'b1;
          w_mem_we_nxt   = 1'b1;
          w_mem_addr_nxt = w_word_addr;
          w_mem_din_nxt  = w_wr_word;
          w_word_nxt     = r_word + 1'b1;
        end
      end
      c_ST_RD_DATA: begin
        if (r_bit_cnt == '0) begin
          w_scan_out_nxt = mem_dout[0];
          w_dat_sh_nxt   = mem_dout >> 1;
        end else begin
          w_scan_out_nxt = r_dat_sh[0];
          w_dat_sh_nxt   = r_dat_sh >> 1;
        end
        w_bit_cnt_nxt = w_dat_last ? '0 : (r_bit_cnt + c_BIT_ONE);
        // Prefetch the next word while its predecessor's last bit goes out.
        if (w_dat_last && !r_last) begin
          w_mem_en_nxt   = 1'b1;
          w_mem_we_nxt   = 1'b0;
          w_mem_addr_nxt = w_word_addr;
          w_word_nxt     = r_word + 1'b1;
          w_last_nxt     = (r_word == r_count);
        end
      end
      c_ST_DONE: begin
        w_done_nxt = 1'b1;
        w_busy_nxt = 1'b0;
      end
      default: begin
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_1 or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      scan_out  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      r_bit_cnt <= '0;
      r_hdr_sh  <= '0;
      r_dat_sh  <= '0;
      r_word    <= '0;
      r_count   <= '0;
      r_base    <= '0;
      r_last    <= 1'b0;
    end else begin
      scan_out  <= w_scan_out_nxt;
      busy      <= w_busy_nxt;
      done      <= w_done_nxt;
      mem_en    <= w_mem_en_nxt;
      mem_we    <= w_mem_we_nxt;
      mem_addr  <= w_mem_addr_nxt;
      mem_din   <= w_mem_din_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_hdr_sh  <= w_hdr_sh_nxt;
      r_dat_sh  <= w_dat_sh_nxt;
      r_word    <= w_word_nxt;
      r_count   <= w_count_nxt;
      r_base    <= w_base_nxt;
      r_last    <= w_last_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_scan_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_scan_burst_ctrl
// Purpose  : Scoreboard bench for sram_scan_burst_ctrl with a behavioural SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_scan_burst_ctrl;

  localparam int DW = 32;
  localparam int AW = 11;
  localparam int CW = 16;
  localparam int HW = 1 + CW + AW;

  typedef struct {
    int            cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } strobe_t;

  logic          clk_1 = 1'b0;
  logic          rst_n_sync = 1'b0;
  logic          scan_in = 1'b0;
  logic          scan_out, busy, done, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  logic [DW-1:0] sram [0:(1<<AW)-1];
  logic          bk_we = 1'b0;
  logic [AW-1:0] bk_addr = '0;
  logic [DW-1:0] bk_data = '0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int stray = 0;

  strobe_t       exp_mem [$];
  logic [DW-1:0] exp_rd [$];
  int            exp_done [$];
  logic [DW-1:0] frame_words [4];

  sram_scan_burst_ctrl #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk_1      (clk_1),
    .rst_n_sync (rst_n_sync),
    .scan_in    (scan_in),
    .scan_out   (scan_out),
    .busy       (busy),
    .done       (done),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  initial forever #5 clk_1 = ~clk_1;

  always @(posedge clk_1) cyc <= cyc + 1;

  // Read data is only meaningful in the cycle after a read strobe.
  assign mem_dout = (mem_en && !mem_we) ? sram[mem_addr] : 32'hA5A5_5A5A;

  always @(posedge clk_1) begin
    if (mem_en && mem_we) sram[mem_addr] <= mem_din;
    else if (bk_we)       sram[bk_addr]  <= bk_data;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({scan_out, busy, done, mem_en, mem_we, mem_addr, mem_din});
  endfunction

  // ---------------- monitor ----------------
  logic          rd_pend = 1'b0;
  logic          rd_act  = 1'b0;
  int            rd_bit  = 0;
  logic [DW-1:0] rd_word = '0;
  strobe_t       m_e;

  always @(negedge clk_1) begin
    if (rd_pend) begin
      rd_act  = 1'b1;
      rd_bit  = 0;
      rd_pend = 1'b0;
    end
    if (rd_act) begin
      rd_word[rd_bit] = scan_out;
      if (rd_bit == DW - 1) begin
        rd_act = 1'b0;
        if (exp_rd.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL read_word: got 0x%0h, expected no word", rd_word);
        end else begin
          check("read_word", 64'(rd_word), 64'(exp_rd.pop_front()));
        end
      end else begin
        rd_bit++;
      end
    end else if (scan_out) begin
      stray++;
    end
    if (mem_en) begin
      if (exp_mem.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL strobe: got we=%0b addr=0x%0h at edge %0d, expected none", mem_we, mem_addr, cyc);
      end else begin
        m_e = exp_mem.pop_front();
        check("strobe{edge,we,addr,din}",
              {4'h0, 12'(cyc), 3'b0, mem_we, 1'b0, mem_addr, (mem_we ? mem_din : 32'h0)},
              {4'h0, 12'(m_e.cyc), 3'b0, m_e.we, 1'b0, m_e.addr, m_e.din});
      end
      if (!mem_we) rd_pend = 1'b1;
    end
    if (done) begin
      if (exp_done.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL done_edge: got done at edge %0d, expected none", cyc);
      end else begin
        check("done_edge", 64'(cyc), 64'(exp_done.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_frame(input logic rw, input int count, input logic [AW-1:0] base);
    int s, d;
    logic [HW-1:0] hdr;
    strobe_t e;
    hdr = {base, CW'(count), rw};
    scan_in = 1'b1;
    s = cyc + 1;
    for (int i = 0; i <= count; i++) begin
      e.we   = rw;
      e.addr = base + AW'(i);
      e.din  = rw ? frame_words[i] : 32'h0;
      e.cyc  = rw ? (s + HW + (i + 1) * DW) : (s + HW + 1 + i * DW);
      exp_mem.push_back(e);
      if (!rw) exp_rd.push_back(frame_words[i]);
    end
    d = rw ? (s + HW + (count + 1) * DW + 1) : (s + HW + 2 + (count + 1) * DW);
    exp_done.push_back(d);
    for (int b = 0; b < HW; b++) begin
      @(negedge clk_1);
      scan_in = hdr[b];
    end
    check("busy_in_frame", 64'(busy), 64'(1));
    if (rw) begin
      for (int i = 0; i <= count; i++) begin
        for (int b = 0; b < DW; b++) begin
          @(negedge clk_1);
          scan_in = frame_words[i][b];
        end
      end
    end
    @(negedge clk_1);
    scan_in = 1'b0;
    while (cyc < d) @(negedge clk_1);
    check("busy_after_done", 64'(busy), 64'(0));
  endtask

  task automatic backdoor(input logic [AW-1:0] a, input logic [DW-1:0] v);
    bk_we = 1'b1; bk_addr = a; bk_data = v;
    @(negedge clk_1);
    bk_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    logic [HW-1:0] hdr;
    strobe_t e;
    repeat (3) @(negedge clk_1);
    check("reset_outputs", outs(), 64'h0);
    rst_n_sync = 1'b1;
    @(negedge clk_1);

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_1);
      if (busy || mem_en) bad++;
    end
    check("idle_quiet", 64'(bad), 64'(0));

    frame_words[0] = 32'hDEADBEEF;
    send_frame(1'b1, 0, 11'h010);
    send_frame(1'b0, 0, 11'h010);   // back-to-back read of the word just written

    frame_words[0] = 32'h1111_1111;
    frame_words[1] = 32'h2222_2222;
    frame_words[2] = 32'h3333_3333;
    send_frame(1'b1, 2, 11'h7FE);

    backdoor(11'h7FE, 32'hCAFE_F00D);
    backdoor(11'h7FF, 32'h0123_4567);
    backdoor(11'h000, 32'h89AB_CDEF);
    frame_words[0] = 32'hCAFE_F00D;
    frame_words[1] = 32'h0123_4567;
    frame_words[2] = 32'h89AB_CDEF;
    send_frame(1'b0, 2, 11'h7FE);

    // Write count=3 aborted by reset at bit 17 of word 1.
    frame_words[0] = 32'h0F0F_1234;
    frame_words[1] = 32'hFFFF_FFFF;
    hdr = {11'h100, 16'd3, 1'b1};
    scan_in = 1'b1;
    e.cyc = cyc + 1 + HW + DW; e.we = 1'b1; e.addr = 11'h100; e.din = 32'h0F0F_1234;
    exp_mem.push_back(e);
    for (int b = 0; b < HW; b++) begin @(negedge clk_1); scan_in = hdr[b]; end
    for (int b = 0; b < DW; b++) begin @(negedge clk_1); scan_in = frame_words[0][b]; end
    for (int b = 0; b < 17; b++) begin @(negedge clk_1); scan_in = frame_words[1][b]; end
    @(negedge clk_1);
    check("busy_before_abort", 64'(busy), 64'(1));
    rst_n_sync = 1'b0;
    scan_in = 1'b0;
    #1;
    check("abort_outputs", outs(), 64'h0);
    repeat (3) @(negedge clk_1);
    rst_n_sync = 1'b1;
    repeat (5) @(negedge clk_1);
    check("post_abort_quiet", outs(), 64'h0);

    frame_words[0] = 32'h0BAD_CAFE;
    send_frame(1'b1, 0, 11'h123);
    send_frame(1'b0, 0, 11'h123);

    repeat (5) @(negedge clk_1);
    check("stray_scan_out_cycles", 64'(stray), 64'(0));
    check("pending_strobes", 64'(exp_mem.size()), 64'(0));
    check("pending_reads", 64'(exp_rd.size()), 64'(0));
    check("pending_dones", 64'(exp_done.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_scan_burst_ctrl.md
# sram_scan_burst_ctrl

Serial-scan burst controller that loads and dumps an on-chip SRAM macro through a single-bit scan port. It replaces the fixed 32-bit, clock-divided scan wrapper with a single-clock engine, parametrised in data, address and burst-count width. It adds framed commands (start bit), back-to-back burst reads and writes with no gap bits, address wrap-around, and busy/done status. It sits between the chip scan pins and a generic synchronous SRAM port (1-cycle read latency).

## Interface
- DATA_W, 32: SRAM word width; multiple of 8.
- ADDR_W, 11: SRAM address width.
- CNT_W, 16: burst-count field width; words per burst = count+1.
- clk_1  in  1  scan/SRAM clock; all logic on rising edge.
- rst_n_sync  in  1  reset, asynchronous, active-low.
- scan_in  in  1  serial command/data in, LSB-first.
- scan_out  out  1  serial read data out, LSB-first, registered.
- busy  out  1  high from start bit accepted until done.
- done  out  1  one-cycle pulse at burst completion.
- mem_en  out  1  SRAM access strobe, one cycle per word.
- mem_we  out  1  1 = write, 0 = read; valid with mem_en.
- mem_addr  out  ADDR_W  SRAM address.
- mem_din  out  DATA_W  SRAM write data.
- mem_dout  in  DATA_W  SRAM read data, valid the cycle after a read mem_en.

## Operation
- Frame: start bit (1) | header HDR_W = 1+CNT_W+ADDR_W bits | payload.
- Header, LSB-first: bit0 = rw (1 = write); bits [CNT_W:1] = count; bits [HDR_W-1:CNT_W+1] = base address.
- States: IDLE, HDR, WR_DATA, RD_DATA, DONE.
- IDLE: scan_in=0 ignored; scan_in=1 -> HDR, busy=1, header bit counter cleared.
- HDR: shift HDR_W bits; on the last bit -> WR_DATA (rw=1) or RD_DATA (rw=0); word index i=0.
- WR_DATA: shift DATA_W bits per word. On the edge sampling bit DATA_W-1, register mem_din={scan_in, shreg[DATA_W-1:1]}, mem_addr=base+i, mem_we=1, mem_en=1. Shifting of word i+1 continues on the next edge with no gap bit. After word count, -> DONE.
- RD_DATA: issue a read (mem_en=1, mem_we=0, mem_addr=base+i) for word 0 on the edge after the last header bit; capture mem_dout into the output shifter on the following edge. Each later word is fetched while bit DATA_W-2 of the previous word is being shifted out, so its bit0 directly follows bit DATA_W-1 of the previous word. The read for word count+1 is never issued.
- Address arithmetic: mem_addr = (base + i) mod 2^ADDR_W; i is a CNT_W-bit counter; wrap from all-ones to 0 is silent.
- DONE: done=1 for one cycle, busy=0, -> IDLE. scan_in is ignored in DONE.
- scan_out = 0 whenever not shifting read data.
- mem_en is never high for two consecutive cycles in write mode. mem_din and mem_addr hold their last values between strobes.

## Timing
- Reset (async assert, any state): scan_out=0, busy=0, done=0, mem_en=0, mem_we=0, mem_addr=0, mem_din=0, state=IDLE, all counters and shifters 0. Reset mid-burst aborts immediately; no partial write strobe is issued.
- Edge numbering: edge S samples the start bit; edges S+1..S+HDR_W sample the header; busy registered high at S.
- Write word i: last data bit sampled at edge S+HDR_W+(i+1)·DATA_W; mem_en high during the following cycle.
- Write done: registered one edge after the final mem_en edge.
- Read: mem_en high after edge S+HDR_W+1. Word 0 bit0 is on scan_out after edge S+HDR_W+2. Word i bit b is on scan_out after edge S+HDR_W+2+i·DATA_W+b.
- Read done: registered on the edge after word count bit DATA_W-1 is driven. scan_out returns to 0 on that same edge.
- A new start bit is accepted on the first edge after done has pulsed (state IDLE).

## Test plan
- Single write, count=0, base=0x010, data 0xDEADBEEF -> exactly one mem_en with mem_we=1, mem_addr=0x010, mem_din=0xDEADBEEF; done 1 cycle later; busy low afterwards.
- Burst write, count=2, base=0x7FE, data 0x11111111/0x22222222/0x33333333 back-to-back -> strobes at 0x7FE, 0x7FF, 0x000 spaced exactly DATA_W cycles apart with the matching data.
- Burst read, count=2, base=0x7FE, SRAM model preloaded -> scan_out emits the three words LSB-first contiguously, word 0 bit0 at edge S+HDR_W+2, reads at 0x7FE, 0x7FF, 0x000, no fourth read issued.
- Idle line: 100 cycles with scan_in=0, then a frame -> no mem_en and busy=0 during idle; the frame executes normally.
- Reset asserted at bit 17 of write word 1 (count=3) -> all outputs 0 immediately; only word 0 was strobed; a new frame after release works.
- Frames back-to-back: read frame started on the first IDLE cycle after the done of a write frame -> read returns the just-written data.
